// File: rtl/syn_lb_master.sv
// syn_lb_master - single-outstanding local-bus initiator turning host commands into LB transactions.
// Every output is a flop; the always_comb block computes each next value and the always_ff block registers it.
module syn_lb_master #(
  parameter int P_DATA_W  = 32,
  parameter int P_ADDR_W  = 16,
  parameter int P_TO_W    = 8,
  parameter int P_TIMEOUT = 255
) (
  input  logic                clk_ir,
  input  logic                rst_il,
  input  logic                cmd_valid_ih,
  output logic                cmd_rdy_oh,
  input  logic                cmd_wr_ih,
  input  logic [P_ADDR_W-1:0] cmd_addr_id,
  input  logic [P_DATA_W-1:0] cmd_wdata_id,
  output logic                rsp_valid_oh,
  input  logic                rsp_rdy_ih,
  output logic                rsp_err_oh,
  output logic [P_DATA_W-1:0] rsp_rdata_od,
  output logic                stray_oh,
  output logic                lb_rd_en_oh,
  output logic                lb_wr_en_oh,
  output logic [P_ADDR_W-1:0] lb_addr_od,
  output logic [P_DATA_W-1:0] lb_wr_data_od,
  input  logic                lb_wr_valid_ih,
  input  logic                lb_rd_valid_ih,
  input  logic [P_DATA_W-1:0] lb_rd_data_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [P_TO_W-1:0] TO_LIM = P_TO_W'(P_TIMEOUT);

  state_t              state, state_d;
  logic                is_wr, is_wr_d;
  logic [P_TO_W-1:0]   cnt, cnt_d;
  logic                cmd_rdy_d, rsp_valid_d, rsp_err_d, stray_d;
  logic                lb_rd_en_d, lb_wr_en_d;
  logic [P_DATA_W-1:0] rsp_rdata_d, lb_wr_data_d;
  logic [P_ADDR_W-1:0] lb_addr_d;
  logic                match, other, any_valid;

  assign match     = is_wr ? lb_wr_valid_ih : lb_rd_valid_ih;
  assign other     = is_wr ? lb_rd_valid_ih : lb_wr_valid_ih;
  assign any_valid = lb_wr_valid_ih | lb_rd_valid_ih;

  always_comb begin
    state_d      = state;
    is_wr_d      = is_wr;
    cnt_d        = cnt;
    cmd_rdy_d    = cmd_rdy_oh;
    rsp_valid_d  = rsp_valid_oh;
    rsp_err_d    = rsp_err_oh;
    rsp_rdata_d  = rsp_rdata_od;
    stray_d      = 1'b0;
    lb_rd_en_d   = 1'b0;
    lb_wr_en_d   = 1'b0;
    lb_addr_d    = lb_addr_od;
    lb_wr_data_d = lb_wr_data_od;
    case (state)
      IDLE: begin
        stray_d = any_valid;
        if (cmd_valid_ih && cmd_rdy_oh) begin
          is_wr_d      = cmd_wr_ih;
          lb_addr_d    = cmd_addr_id;
          lb_wr_data_d = cmd_wdata_id;
          lb_wr_en_d   = cmd_wr_ih;
          lb_rd_en_d   = !cmd_wr_ih;
          cmd_rdy_d    = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        stray_d = other;
        // A completing valid beats a simultaneous timeout.
        if (match) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = is_wr ? '0 : lb_rd_data_id;
          state_d     = RESP;
        end else if (state == ISSUE) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = (cnt == TO_LIM) ? cnt : cnt + 1'b1;
          if (cnt_d == TO_LIM) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        stray_d = any_valid;
        if (rsp_rdy_ih) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          cmd_rdy_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state         <= IDLE;
      is_wr         <= 1'b0;
      cnt           <= '0;
      cmd_rdy_oh    <= 1'b1;
      rsp_valid_oh  <= 1'b0;
      rsp_err_oh    <= 1'b0;
      rsp_rdata_od  <= '0;
      stray_oh      <= 1'b0;
      lb_rd_en_oh   <= 1'b0;
      lb_wr_en_oh   <= 1'b0;
      lb_addr_od    <= '0;
      lb_wr_data_od <= '0;
    end else begin
      state         <= state_d;
      is_wr         <= is_wr_d;
      cnt           <= cnt_d;
      cmd_rdy_oh    <= cmd_rdy_d;
      rsp_valid_oh  <= rsp_valid_d;
      rsp_err_oh    <= rsp_err_d;
      rsp_rdata_od  <= rsp_rdata_d;
      stray_oh      <= stray_d;
      lb_rd_en_oh   <= lb_rd_en_d;
      lb_wr_en_oh   <= lb_wr_en_d;
      lb_addr_od    <= lb_addr_d;
      lb_wr_data_od <= lb_wr_data_d;
    end
  end

endmodule

// File: tb/tb_syn_lb_master.sv
// tb/tb_syn_lb_master.sv - directed self-checking bench for syn_lb_master.
module tb_syn_lb_master;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_rdy, cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_rdy, rsp_err;
  logic [31:0] rsp_rdata;
  logic        stray, lb_rd_en, lb_wr_en;
  logic [15:0] lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid, lb_rd_valid;
  logic [31:0] lb_rd_data;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  syn_lb_master #(.P_DATA_W(32), .P_ADDR_W(16), .P_TO_W(8), .P_TIMEOUT(255)) dut (
    .clk_ir(clk), .rst_il(rst_n),
    .cmd_valid_ih(cmd_valid), .cmd_rdy_oh(cmd_rdy), .cmd_wr_ih(cmd_wr),
    .cmd_addr_id(cmd_addr), .cmd_wdata_id(cmd_wdata),
    .rsp_valid_oh(rsp_valid), .rsp_rdy_ih(rsp_rdy), .rsp_err_oh(rsp_err),
    .rsp_rdata_od(rsp_rdata), .stray_oh(stray),
    .lb_rd_en_oh(lb_rd_en), .lb_wr_en_oh(lb_wr_en),
    .lb_addr_od(lb_addr), .lb_wr_data_od(lb_wr_data),
    .lb_wr_valid_ih(lb_wr_valid), .lb_rd_valid_ih(lb_rd_valid), .lb_rd_data_id(lb_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (lb_wr_en) wr_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_rdy = 1'b0; lb_wr_valid = 1'b0; lb_rd_valid = 1'b0; lb_rd_data = '0;
    repeat (2) tick();
    check("reset_outs", {cmd_rdy, rsp_valid, rsp_err, stray, lb_rd_en, lb_wr_en}, 6'b100000);
    check("reset_data", {rsp_rdata, lb_addr, lb_wr_data}, 80'h0);
    rst_n = 1'b1;
    tick();

    // Write 0x1004 <- 0xA5A50001, stray rd_valid in S+1, wr_valid at S+3
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h1004; cmd_wdata = 32'hA5A5_0001;
    wr_pulses = 0;
    tick();
    cmd_valid = 1'b0; cmd_wdata = 32'hFFFF_FFFF;
    check("wr_strobe", {lb_wr_en, lb_rd_en, cmd_rdy}, 3'b100);
    check("wr_addr", lb_addr, 16'h1004);
    check("wr_data", lb_wr_data, 32'hA5A5_0001);
    tick();
    check("wr_strobe_drop", lb_wr_en, 1'b0);
    lb_rd_valid = 1'b1;
    tick();
    lb_rd_valid = 1'b0;
    check("wr_stray", {stray, rsp_valid}, 2'b10);
    tick();
    check("wr_stray_end", {stray, rsp_valid}, 2'b00);
    lb_wr_valid = 1'b1;
    tick();
    lb_wr_valid = 1'b0;
    check("wr_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("wr_rdata", rsp_rdata, 32'h0);
    check("wr_pulses", wr_pulses, 1);
    check("wr_addr_held", lb_addr, 16'h1004);
    consume();
    check("wr_exit", {rsp_valid, cmd_rdy}, 2'b01);

    // Valid while idle
    lb_wr_valid = 1'b1;
    tick();
    lb_wr_valid = 1'b0;
    check("idle_stray", {stray, rsp_valid, cmd_rdy, lb_wr_en}, 4'b1010);
    tick();
    check("idle_stray_end", stray, 1'b0);

    // Read 0x2010 with same-cycle responder
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h2010;
    tick();
    cmd_valid = 1'b0;
    check("rd_strobe", {lb_rd_en, lb_wr_en}, 2'b10);
    check("rd_addr", lb_addr, 16'h2010);
    lb_rd_valid = 1'b1; lb_rd_data = 32'h1234_5678;
    tick();
    lb_rd_valid = 1'b0; lb_rd_data = 32'h0;
    check("rd_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("rd_rdata", rsp_rdata, 32'h1234_5678);

    // Backpressure with a pending command
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h3000; cmd_wdata = 32'h0000_3333;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", {rsp_valid, cmd_rdy, lb_wr_en, rsp_rdata}, {3'b100, 32'h1234_5678});
    end
    consume();
    check("bp_exit", {rsp_valid, cmd_rdy, lb_wr_en}, 3'b010);
    tick();
    cmd_valid = 1'b0;
    check("bp_accept", {lb_wr_en, lb_addr, lb_wr_data}, {1'b1, 16'h3000, 32'h0000_3333});
    lb_wr_valid = 1'b1;
    tick();
    lb_wr_valid = 1'b0;
    check("bp_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0});
    consume();

    // Read timeout, then late valid
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h4000; lb_rd_data = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0;
    repeat (255) tick();
    check("to_before", rsp_valid, 1'b0);
    tick();
    check("to_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 32'h0});
    lb_rd_valid = 1'b1;
    tick();
    lb_rd_valid = 1'b0;
    check("to_late", {stray, rsp_valid, rsp_err, rsp_rdata}, {3'b111, 32'h0});
    consume();

    // Valid arriving on the timeout cycle wins
    cmd_valid = 1'b1; cmd_addr = 16'h4004;
    tick();
    cmd_valid = 1'b0;
    repeat (255) tick();
    lb_rd_valid = 1'b1; lb_rd_data = 32'hCAFE_0001;
    tick();
    lb_rd_valid = 1'b0; lb_rd_data = 32'h0;
    check("to_race", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hCAFE_0001});
    consume();

    // Reset while waiting
    cmd_valid = 1'b1; cmd_addr = 16'h5000;
    tick();
    cmd_valid = 1'b0;
    check("rst_strobe", lb_rd_en, 1'b1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("rst_async", {lb_rd_en, lb_wr_en, rsp_valid, cmd_rdy, lb_addr}, {4'b0001, 16'h0});
    tick();
    rst_n = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h6000; cmd_wdata = 32'h0BAD_F00D;
    tick();
    cmd_valid = 1'b0;
    check("post_rst_issue", {lb_wr_en, lb_addr, lb_wr_data}, {1'b1, 16'h6000, 32'h0BAD_F00D});
    lb_wr_valid = 1'b1;
    tick();
    lb_wr_valid = 1'b0;
    check("post_rst_rsp", {rsp_valid, rsp_err}, 2'b10);
    consume();
    check("post_rst_idle", {cmd_rdy, rsp_valid}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
